// File: rtl/psg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psg_pkg
// Brief    : Shared defaults and drain-FSM state encoding for the PSG write
//            queue (psg_wr_queue / psg_fifo).
// Revision : 1.0 - initial release
// ============================================================================
package psg_pkg;

  // Default FIFO depth (entries) and minimum strobe-to-strobe spacing (cycles)
  localparam int unsigned C_DEPTH_DEF    = 8;
  localparam int unsigned C_HOLD_CYC_DEF = 32;

  // Hold counter width; HOLD_CYC tops out at 255
  localparam int unsigned C_CNT_W = 8;

  // Drain FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } psg_state_e;

endpackage
`default_nettype wire

// File: rtl/psg_fifo.sv
`default_nettype none
// ============================================================================
// Module   : psg_fifo
// Brief    : DEPTH x WIDTH synchronous FIFO with show-ahead head, full/empty
//            flags and occupancy count. DEPTH must be a power of two so the
//            pointers wrap naturally.
// Revision : 1.0 - initial release
// ============================================================================
module psg_fifo import psg_pkg::*; #(
  parameter int unsigned DEPTH = C_DEPTH_DEF,
  parameter int unsigned WIDTH = 8
) (
  input  logic                      cpuclk,
  input  logic                      reset,
  input  logic                      push_i,
  input  logic [WIDTH-1:0]          din_i,
  input  logic                      pop_i,
  output logic [WIDTH-1:0]          dout_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;

  // Storage write; contents need no reset because count_q gates visibility
  always_ff @(posedge cpuclk) begin
    if (push_i) begin
      mem_q[wptr_q] <= din_i;
    end
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves count alone
  always_ff @(posedge cpuclk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop_i) begin
        rptr_q <= rptr_q + AW'(1);
      end
      if (push_i && !pop_i) begin
        count_q <= count_q + (AW+1)'(1);
      end else if (pop_i && !push_i) begin
        count_q <= count_q - (AW+1)'(1);
      end
    end
  end

  assign dout_o  = mem_q[rptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/psg_wr_queue.sv
`default_nettype none
// ============================================================================
// Module   : psg_wr_queue
// Brief    : Buffers CPU writes to the PSG port and replays them to the sound
//            generator as one-cycle strobes spaced at least HOLD_CYC cycles
//            apart. Stalls the CPU only when the FIFO is full and no slot is
//            being freed in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module psg_wr_queue import psg_pkg::*; #(
  parameter int unsigned DEPTH    = C_DEPTH_DEF,
  parameter int unsigned HOLD_CYC = C_HOLD_CYC_DEF
) (
  input  logic                      cpuclk,
  input  logic                      reset,
  input  logic                      cpu_cs,
  input  logic                      cpu_wr,
  input  logic [7:0]                cpu_din,
  output logic                      cpu_wait,
  output logic                      psg_ce,
  output logic                      psg_we,
  output logic [7:0]                psg_data,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      busy
);

  // HOLD is entered one cycle after the strobe and the FSM spends one cycle
  // in IDLE before the next pop, so HOLD covers HOLD_CYC-2 cycles.
  localparam logic [C_CNT_W-1:0] C_HOLD_LOAD = C_CNT_W'(HOLD_CYC - 2);

  logic                   req;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [7:0]             fifo_head;

  logic                   taken_q;
  logic                   taken_d;
  psg_state_e             state_q;
  logic [C_CNT_W-1:0]     cnt_q;
  logic                   psg_ce_q;
  logic [7:0]             psg_data_q;

  psg_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .cpuclk  (cpuclk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (cpu_din),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (level)
  );

  // A level strobe is accepted once; a full FIFO still accepts if the head
  // leaves at the same edge.
  assign req      = cpu_cs & cpu_wr;
  assign pop      = (state_q == IDLE) & ~fifo_empty;
  assign push     = req & ~taken_q & (~fifo_full | pop);
  assign cpu_wait = req & ~taken_q & fifo_full & ~pop;

  // Acceptance flag: set on push, cleared the first cycle the strobe is low
  always_comb begin
    taken_d = taken_q;
    if (push) begin
      taken_d = 1'b1;
    end else if (!req) begin
      taken_d = 1'b0;
    end
  end

  // Register the acceptance flag
  always_ff @(posedge cpuclk or posedge reset) begin
    if (reset) begin
      taken_q <= 1'b0;
    end else begin
      taken_q <= taken_d;
    end
  end

  // Drain FSM: pop head, strobe one cycle, then hold off before next pop
  always_ff @(posedge cpuclk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      psg_ce_q   <= 1'b0;
      psg_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            psg_data_q <= fifo_head;
            psg_ce_q   <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          psg_ce_q <= 1'b0;
          cnt_q    <= C_HOLD_LOAD;
          state_q  <= HOLD;
        end
        HOLD: begin
          // Leave as the counter reaches zero; a zero load exits at once
          if (cnt_q <= C_CNT_W'(1)) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - C_CNT_W'(1);
          end
        end
        default: begin
          psg_ce_q <= 1'b0;
          cnt_q    <= '0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign psg_ce   = psg_ce_q;
  assign psg_we   = psg_ce_q;
  assign psg_data = psg_data_q;
  assign busy     = ~fifo_empty | (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_psg_wr_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_psg_wr_queue
// Brief    : Directed self-checking bench for psg_wr_queue with a byte
//            scoreboard matched against every PSG strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psg_wr_queue;

  logic       cpuclk = 1'b0;
  logic       reset;
  logic       cpu_cs;
  logic       cpu_wr;
  logic [7:0] cpu_din;
  logic       cpu_wait;
  logic       psg_ce;
  logic       psg_we;
  logic [7:0] psg_data;
  logic [3:0] level;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         pulses = 0;
  int         last_ce_cyc = -1;
  logic       prev_ce = 1'b0;
  logic [3:0] acc_lvl = '0;
  logic [7:0] sb [$];
  int         pcyc [$];
  logic [7:0] seq3 [3] = '{8'h80, 8'h3F, 8'h90};

  psg_wr_queue #(
    .DEPTH    (8),
    .HOLD_CYC (32)
  ) dut (
    .cpuclk   (cpuclk),
    .reset    (reset),
    .cpu_cs   (cpu_cs),
    .cpu_wr   (cpu_wr),
    .cpu_din  (cpu_din),
    .cpu_wait (cpu_wait),
    .psg_ce   (psg_ce),
    .psg_we   (psg_we),
    .psg_data (psg_data),
    .level    (level),
    .busy     (busy)
  );

  always #5 cpuclk = ~cpuclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample just after the edge and match any strobe to the scoreboard
  task automatic tick();
    logic [7:0] e;
    @(posedge cpuclk);
    #1;
    cyc++;
    if (psg_ce === 1'b1) begin
      pulses++;
      last_ce_cyc = cyc;
      pcyc.push_back(cyc);
      check("ce_single_cycle", {31'd0, prev_ce}, 32'd0);
      check("we_equals_ce", {31'd0, psg_we}, 32'd1);
      check("strobe_expected", {31'd0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("strobe_data", {24'd0, psg_data}, {24'd0, e});
      end
    end
    prev_ce = psg_ce;
  endtask

  // Raise the strobe and wait (bounded) for the edge that accepts it
  task automatic strobe(input logic [7:0] b, output int stalled);
    logic w;
    cpu_cs  = 1'b1;
    cpu_wr  = 1'b1;
    cpu_din = b;
    stalled = 0;
    w = 1'b1;
    for (int n = 0; n < 200 && w; n++) begin
      #1;
      w = cpu_wait;
      acc_lvl = level;
      if (w) stalled++;
      tick();
    end
    if (w) check("accept_timeout", {31'd0, w}, 32'd0);
    sb.push_back(b);
  endtask

  task automatic release_req();
    cpu_cs = 1'b0;
    cpu_wr = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input int lim);
    for (int n = 0; n < lim && busy; n++) tick();
    check("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int st;
    int e0;
    int p0;
    int first_stall;

    // Reset state, with a live request that must not raise cpu_wait
    reset   = 1'b1;
    cpu_cs  = 1'b1;
    cpu_wr  = 1'b1;
    cpu_din = 8'hAA;
    repeat (3) @(posedge cpuclk);
    #1;
    check("rst_level", {28'd0, level}, 32'd0);
    check("rst_psg_ce", {31'd0, psg_ce}, 32'd0);
    check("rst_psg_we", {31'd0, psg_we}, 32'd0);
    check("rst_psg_data", {24'd0, psg_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cpu_wait", {31'd0, cpu_wait}, 32'd0);
    cpu_cs = 1'b0;
    cpu_wr = 1'b0;
    #2 reset = 1'b0;
    tick();

    // Single write: strobe exactly one edge after acceptance
    strobe(8'h9F, st);
    e0 = cyc;
    check("single_level_after_push", {28'd0, level}, 32'd1);
    check("single_ce_at_e0", {31'd0, psg_ce}, 32'd0);
    release_req();
    check("single_ce_at_e1", {31'd0, psg_ce}, 32'd1);
    check("single_latency", last_ce_cyc, e0 + 1);
    check("single_level_after_pop", {28'd0, level}, 32'd0);
    tick();
    check("single_ce_at_e2", {31'd0, psg_ce}, 32'd0);
    check("single_data_held", {24'd0, psg_data}, 32'h9F);
    wait_idle(100);

    // Long strobe: one push, one pulse
    p0 = pulses;
    cpu_cs  = 1'b1;
    cpu_wr  = 1'b1;
    cpu_din = 8'h80;
    sb.push_back(8'h80);
    repeat (10) tick();
    check("long_level", {28'd0, level}, 32'd0);
    release_req();
    wait_idle(100);
    check("long_one_pulse", pulses - p0, 32'd1);
    check("long_sb_empty", sb.size(), 32'd0);

    // Back-to-back bytes: strobes exactly HOLD_CYC apart
    pcyc.delete();
    for (int i = 0; i < 3; i++) begin
      strobe(seq3[i], st);
      release_req();
    end
    for (int n = 0; n < 200 && pcyc.size() < 3; n++) tick();
    check("b2b_pulse_count", pcyc.size(), 32'd3);
    if (pcyc.size() == 3) begin
      check("b2b_spacing_1", pcyc[1] - pcyc[0], 32'd32);
      check("b2b_spacing_2", pcyc[2] - pcyc[1], 32'd32);
    end

    // Ten writes launched while the FSM is holding off: the ninth finds the
    // FIFO full and is taken at the pop edge, where level stays at DEPTH
    p0 = pulses;
    first_stall = -1;
    for (int i = 0; i < 10; i++) begin
      strobe(8'h10 + 8'(i), st);
      if (st > 0) begin
        if (first_stall < 0) first_stall = i;
        check("full_level_before_accept", {28'd0, acc_lvl}, 32'd8);
        check("full_level_push_pop", {28'd0, level}, 32'd8);
        check("full_pop_same_edge", {31'd0, psg_ce}, 32'd1);
      end
      release_req();
    end
    check("first_stalled_strobe", first_stall, 32'd8);
    wait_idle(800);
    check("ten_pulses", pulses - p0, 32'd10);
    check("ten_sb_empty", sb.size(), 32'd0);

    // Reset during HOLD with five bytes queued discards them
    for (int i = 0; i < 6; i++) begin
      strobe(8'hA0 + 8'(i), st);
      release_req();
    end
    check("hold_level5", {28'd0, level}, 32'd5);
    check("hold_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("hold_rst_level", {28'd0, level}, 32'd0);
    check("hold_rst_ce", {31'd0, psg_ce}, 32'd0);
    check("hold_rst_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    repeat (2) tick();
    reset = 1'b0;
    p0 = pulses;
    repeat (80) tick();
    check("hold_no_strobes", pulses - p0, 32'd0);
    check("hold_level_after", {28'd0, level}, 32'd0);

    // Reset mid-ISSUE drops the strobe without waiting for a clock
    strobe(8'h5A, st);
    release_req();
    check("issue_ce_high", {31'd0, psg_ce}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("issue_rst_ce", {31'd0, psg_ce}, 32'd0);
    check("issue_rst_we", {31'd0, psg_we}, 32'd0);
    check("issue_rst_data", {24'd0, psg_data}, 32'd0);
    sb.delete();
    repeat (2) tick();
    reset = 1'b0;
    p0 = pulses;
    repeat (40) tick();
    check("issue_no_strobes", pulses - p0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
